// File: rtl/seven_seg_scan_ctrl_if.sv
// Update channel between game logic and seven_seg_scan_ctrl.
// The producer offers a BCD display value with upd_valid; the controller
// accepts it when upd_ready is high. One nibble per digit, digit 0 in [3:0].
interface seven_seg_scan_ctrl_if #(
    parameter int NUM_DIGITS = 4
);
    logic [4*NUM_DIGITS-1:0] value_in;
    logic                    upd_valid;
    logic                    upd_ready;

    // Game / score logic side
    modport master (
        output value_in,
        output upd_valid,
        input  upd_ready
    );

    // Scan controller side
    modport slave (
        input  value_in,
        input  upd_valid,
        output upd_ready
    );
endinterface

// File: rtl/seven_seg_scan_ctrl.sv
// Multiplexed seven-segment scan controller.
// Drives NUM_DIGITS active-low anodes one digit slot at a time and feeds the
// selected BCD nibble to a shared seven_seg_dec. Each slot opens with
// GUARD_CYCLES of all anodes off so the decoder settles before its anode
// lights. A new display value is captured into a shadow register through a
// valid/ready handshake and moved to the active register only when the digit
// index wraps to 0, so a frame never shows a mix of old and new digits.
// Nibbles above 9 are blanked (anode held off) since the decoder output is
// undefined for them.
// Optional feature: define SCAN_LZB_EN to blank leading-zero digits
// (digit 0 is always shown).
module seven_seg_scan_ctrl #(
    parameter int NUM_DIGITS   = 4,
    parameter int SCAN_DIV     = 50000,
    parameter int GUARD_CYCLES = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    seven_seg_scan_ctrl_if.slave  upd_if,
    input  logic                  disp_en,
    output logic [3:0]            dec_num,
    output logic [NUM_DIGITS-1:0] anode_n,
    output logic                  frame_tick
);

    localparam int CNT_W = $clog2(SCAN_DIV);
    localparam int IDX_W = $clog2(NUM_DIGITS);
    localparam int VAL_W = 4 * NUM_DIGITS;

    localparam logic [CNT_W-1:0] GUARD_LAST = CNT_W'(GUARD_CYCLES - 1);
    localparam logic [CNT_W-1:0] SHOW_LAST  = CNT_W'(SCAN_DIV - 1);
    localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(NUM_DIGITS - 1);

    typedef enum logic {
        ST_GUARD = 1'b0,
        ST_SHOW  = 1'b1
    } state_t;

    state_t                  state_q, state_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic [CNT_W-1:0]        slot_cnt_q, slot_cnt_d;
    logic [VAL_W-1:0]        active_q, active_d;
    logic [VAL_W-1:0]        shadow_q, shadow_d;
    logic                    pending_q, pending_d;
    logic [3:0]              dec_num_q, dec_num_d;
    logic [NUM_DIGITS-1:0]   anode_n_q, anode_n_d;
    logic                    frame_tick_q, frame_tick_d;
    logic                    wrap;
    logic [NUM_DIGITS-1:0]   blank;

    // Slot sequencing: guard phase, show phase, then advance the digit index.
    always_comb begin
        // NOTE: every combinational output gets a default first, so no path
        // leaves it unassigned and no latch is inferred.
        state_d    = state_q;
        idx_d      = idx_q;
        slot_cnt_d = slot_cnt_q + CNT_W'(1);
        wrap       = 1'b0;
        unique case (state_q)
            ST_GUARD: begin
                if (slot_cnt_q == GUARD_LAST) begin
                    state_d = ST_SHOW;
                end
            end
            ST_SHOW: begin
                if (slot_cnt_q == SHOW_LAST) begin
                    state_d    = ST_GUARD;
                    slot_cnt_d = '0;
                    if (idx_q == IDX_LAST) begin
                        idx_d = '0;
                        wrap  = 1'b1;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
            end
            default: state_d = ST_GUARD;
        endcase
    end

    // Double buffer: accept into shadow, commit to active at the frame wrap.
    // Accept and commit are mutually exclusive since one needs pending low and
    // the other pending high, so an update taken on the wrap edge waits a frame.
    always_comb begin
        active_d  = active_q;
        shadow_d  = shadow_q;
        pending_d = pending_q;
        if (wrap && pending_q) begin
            active_d  = shadow_q;
            pending_d = 1'b0;
        end
        if (upd_if.upd_valid && !pending_q) begin
            shadow_d  = upd_if.value_in;
            pending_d = 1'b1;
        end
    end

    // Per-digit blanking: invalid BCD, plus leading zeros when enabled.
    // Derived from active only, so it changes solely at commit.
    always_comb begin
        for (int i = 0; i < NUM_DIGITS; i++) begin
            blank[i] = (active_q[4*i +: 4] > 4'd9);
        end
`ifdef SCAN_LZB_EN
        begin : lzb
            logic zero_above;
            zero_above = 1'b1;
            for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
                zero_above = zero_above && (active_q[4*i +: 4] == 4'd0);
                if (zero_above) begin
                    blank[i] = 1'b1;
                end
            end
        end
`endif
    end

    // Registered outputs computed from the next scan position, so they line up
    // with the state register and disp_en shows up one cycle later.
    always_comb begin
        dec_num_d    = dec_num_q;
        anode_n_d    = '1;
        frame_tick_d = wrap;
        // Load the code on entry to GUARD; it is then stable before SHOW.
        if (state_q == ST_SHOW && state_d == ST_GUARD) begin
            for (int i = 0; i < NUM_DIGITS; i++) begin
                if (idx_d == IDX_W'(i)) begin
                    dec_num_d = active_d[4*i +: 4];
                end
            end
        end
        if (state_d == ST_SHOW && disp_en) begin
            for (int i = 0; i < NUM_DIGITS; i++) begin
                if (idx_d == IDX_W'(i) && !blank[i]) begin
                    anode_n_d[i] = 1'b0;
                end
            end
        end
    end

    // State and output registers; reset discards any pending shadow value.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments only, so every
        // flop samples the pre-edge value of the others.
        if (!rst_n) begin
            state_q      <= ST_GUARD;
            idx_q        <= '0;
            slot_cnt_q   <= '0;
            active_q     <= '0;
            shadow_q     <= '0;
            pending_q    <= 1'b0;
            dec_num_q    <= '0;
            anode_n_q    <= '1;
            frame_tick_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            slot_cnt_q   <= slot_cnt_d;
            active_q     <= active_d;
            shadow_q     <= shadow_d;
            pending_q    <= pending_d;
            dec_num_q    <= dec_num_d;
            anode_n_q    <= anode_n_d;
            frame_tick_q <= frame_tick_d;
        end
    end

    assign dec_num          = dec_num_q;
    assign anode_n          = anode_n_q;
    assign frame_tick       = frame_tick_q;
    assign upd_if.upd_ready = ~pending_q;

endmodule
